mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, loads and stores).
- Grants one access at a time and sequences the fixed-latency memory cycle.
- Returns read data with a one-cycle valid pulse.
- Generates per-stage stall signals for the pipeline control and hazard logic.

Parameters:
- ADDR_W, 12, memory word address width
- INST_W, 19, memory word width (instruction width)
- DATA_W, 8, data-stage word width (low DATA_W bits of a memory word)
- MEM_LAT, 2, memory read latency in cycles; legal range 1..7

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  INST_W  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- flush  in  1  taken branch/jump; kills the outstanding fetch
- dm_req  in  1  data request; level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- stall_if  out  1  if_req & ~if_valid
- stall_mem  out  1  dm_req & ~dm_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  INST_W  memory write data; dm_wdata zero-extended
- mem_rdata  in  INST_W  memory read data

Behaviour:
- Reset (reset=0, asynchronous), with outputs held while reset is low:
  - State goes to IDLE.
  - mem_en, mem_we, if_valid and dm_valid are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - Grant and kill flags are cleared.
  - Any in-flight access is abandoned; no valid is produced for it.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant dm (fixed priority; see Optional Feature).
  - On the grant edge: latch address, write enable, write data and grant id into registers, load the counter with MEM_LAT, and go to BUSY.
- BUSY:
  - mem_en=1 in the first BUSY cycle only.
  - mem_we=1 only if the grant is dm and dm_we=1.
  - mem_addr and mem_wdata come from the registers and are stable for the whole of BUSY.
  - The counter decrements each cycle.
  - On the edge where the counter reaches 1: capture mem_rdata into if_rdata (full word) or dm_rdata (low DATA_W bits) for reads, then go to DONE.
  - Stores capture nothing; dm_rdata keeps its old value.
  - BUSY lasts exactly MEM_LAT cycles.
- DONE:
  - Lasts one cycle.
  - Asserts if_valid or dm_valid for the granted requester.
  - No arbitration takes place in DONE.
  - Always returns to IDLE.
- Latency from request-high in IDLE to valid is MEM_LAT+1 cycles; minimum issue interval is MEM_LAT+2 cycles.
- Stalls are combinational: stall_if = if_req & ~if_valid; stall_mem = dm_req & ~dm_valid.
- Flush:
  - flush=1 while the granted fetch is in BUSY sets kill.
  - In DONE, if_valid = ~kill & ~flush.
  - The memory cycle always runs to completion; it is never aborted.
  - kill clears on entry to IDLE.
  - flush has no effect while IDLE, and no effect on dm accesses.
- Requests that drop while not granted are simply not served; requests that drop mid-access do not abort the access.
- Zero-extension: mem_wdata = {INST_W-DATA_W zeros, dm_wdata}.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: on a simultaneous if_req & dm_req in IDLE, grant the requester that did not win the last contested grant.
  - A last-winner register holds that requester; it resets to "if", so dm wins the first contest.
  - Uncontested grants do not update the register.
- Undefined: fixed dm priority; the register is absent.

Test Plan:
- Single fetch, MEM_LAT=2, if_addr=0x010, mem_rdata=0x5A5A5 -> mem_en pulses in cycle 1 after grant, if_valid high in cycle 3, if_rdata=0x5A5A5, stall_if high in cycles 0–2.
- Store dm_addr=0x020, dm_wdata=0xC3 -> mem_we=1, mem_wdata=0x000C3 with mem_en; dm_valid in cycle 3; dm_rdata unchanged.
- if_req and dm_req asserted together (fixed priority) -> dm served first (valid in cycle 3), fetch granted in IDLE at cycle 4, if_valid in cycle 7.
- Fetch in flight, flush pulsed in first BUSY cycle -> if_valid stays 0 in DONE, FSM back in IDLE, next fetch served normally.
- reset driven low mid-BUSY of a load -> all outputs 0 immediately; after release, no dm_valid for the abandoned load and a re-request completes in MEM_LAT+1 cycles.
- With MEM_ARB_RR_EN, both requests held continuously -> grants alternate dm, if, dm, if.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency unified memory
// between the instruction-fetch requester and the data (load/store) requester.
// One access is in flight at a time; IDLE -> BUSY (MEM_LAT cycles) -> DONE.
// Read data is registered at the end of BUSY and qualified by a one-cycle
// valid pulse in DONE. Legal MEM_LAT range is 1..7 (3-bit latency counter).
//
// Build option: define MEM_ARB_RR_EN to alternate the winner of contested
// grants. Left undefined, the data requester always wins a contest.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int INST_W  = 19,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INST_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  input  logic [INST_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int                CNT_W    = 3;
  localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_gnt_dm;   // 1 = data requester owns the access
  logic                r_we;       // access is a store
  logic                r_kill;     // granted fetch was flushed while in BUSY
  logic [ADDR_W-1:0]   r_addr;
  logic [INST_W-1:0]   r_wdata;
  logic [INST_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;

  logic                w_any_req;
  logic                w_pick_dm;
  logic                w_busy_last;

  assign w_any_req   = if_req | dm_req;
  assign w_busy_last = (r_state == ST_BUSY) && (r_cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
  logic r_last_if;  // winner of the most recent contested grant was fetch

  // On a contest the requester that lost last time wins; an empty history
  // starts as "fetch won", so the data requester takes the first contest.
  assign w_pick_dm = dm_req & (~if_req | r_last_if);

  // Track the winner of contested grants only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_if <= 1'b1;
    end else if ((r_state == ST_IDLE) && if_req && dm_req) begin
      r_last_if <= ~w_pick_dm;
    end
  end
`else
  // Fixed priority: the data requester wins any contest.
  assign w_pick_dm = dm_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic: grant in IDLE, count out BUSY, single-cycle DONE.
  always_comb begin
    // NOTE: the default assignment first means every path drives the
    // signal, so no latch is inferred for an unlisted case.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req)   w_next_state = ST_BUSY;
      ST_BUSY: if (w_busy_last) w_next_state = ST_DONE;
      ST_DONE:                  w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  // Access datapath: latch the granted request, run the latency counter,
  // capture read data on the last BUSY edge, and track fetch kills.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_gnt_dm   <= 1'b0;
      r_we       <= 1'b0;
      r_kill     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt_dm <= w_pick_dm;
            r_we     <= w_pick_dm & dm_we;
            r_addr   <= w_pick_dm ? dm_addr : if_addr;
            r_wdata  <= {{(INST_W-DATA_W){1'b0}}, dm_wdata};
            r_cnt    <= LAT_INIT;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_LAST;
          // A flush only kills the result; the memory cycle still completes.
          if (flush && !r_gnt_dm) r_kill <= 1'b1;
          if (w_busy_last && !r_we) begin
            if (r_gnt_dm) r_dm_rdata <= mem_rdata[DATA_W-1:0];
            else          r_if_rdata <= mem_rdata;
          end
        end
        ST_DONE: begin
          r_kill <= 1'b0;  // cleared as the FSM re-enters IDLE
        end
        default: begin
          r_kill <= 1'b0;
        end
      endcase
    end
  end

  // Memory strobes are only in the first BUSY cycle; address/data hold
  // their latched values throughout the access.
  assign mem_en    = (r_state == ST_BUSY) && (r_cnt == LAT_INIT);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

  // A flush arriving in DONE itself suppresses the fetch pulse combinationally.
  assign if_valid  = (r_state == ST_DONE) & ~r_gnt_dm & ~r_kill & ~flush;
  assign dm_valid  = (r_state == ST_DONE) &  r_gnt_dm;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A behavioural fixed-latency memory
// answers the arbiter; expected completions are queued when a request is
// driven and popped when the matching valid pulse appears.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 12;
  localparam int INST_W  = 19;
  localparam int DATA_W  = 8;
  localparam int MEM_LAT = 2;
  localparam logic [INST_W-1:0] JUNK = 19'h7E5E1;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [INST_W-1:0] if_rdata;
  logic              if_valid;
  logic              flush;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              stall_if;
  logic              stall_mem;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_wdata;
  logic [INST_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .flush    (flush),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit                is_dm;
    logic [INST_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [INST_W-1:0] mem_arr [0:4095];
  bit                wr_seen [0:4095];
  logic [ADDR_W-1:0] rd_addr;
  int                rd_age;

  function automatic logic [INST_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    case (a)
      12'h010: return 19'h5A5A5;
      12'h030: return 19'h12345;
      12'h040: return 19'h1ABCD;
      12'h050: return 19'h00077;
      12'h060: return 19'h2468A;
      12'h070: return 19'h13579;
      12'h071: return 19'h0F0F0;
      12'h072: return 19'h3C3C3;
      12'h073: return 19'h4D4D4;
      12'h080: return 19'h000AA;
      12'h090: return 19'h11111;
      12'h0A0: return 19'h22222;
      default: return {a[6:0], a} ^ 19'h15555;
    endcase
  endfunction

  function automatic logic [INST_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    return wr_seen[a] ? mem_arr[a] : mem_val(a);
  endfunction

  always @(posedge clk) begin
    if (reset && mem_en && mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      wr_seen[mem_addr] <= 1'b1;
    end
  end

  // rd_age counts cycles since the read strobe; data is only driven in the
  // cycle the arbiter must capture it (last BUSY cycle), junk otherwise.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_age  <= 0;
      rd_addr <= '0;
    end else if (mem_en && !mem_we) begin
      rd_addr <= mem_addr;
      rd_age  <= 1;
    end else if (rd_age != 0) begin
      rd_age  <= (rd_age >= MEM_LAT - 1) ? 0 : rd_age + 1;
    end
  end

  always_comb begin
    mem_rdata = JUNK;
    if (MEM_LAT == 1 && mem_en && !mem_we) mem_rdata = rd_mem(mem_addr);
    else if (rd_age != 0 && rd_age == MEM_LAT - 1) mem_rdata = rd_mem(rd_addr);
  end

  // ---------------- helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts just after a rising edge (cycle s); returns n = valid cycle - s,
  // or -1 if no valid appears within budget cycles.
  task automatic wait_valid(input int budget, output int n, output bit got_if,
                            output bit got_dm);
    bit done;
    n = 0; got_if = 0; got_dm = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (if_valid || dm_valid) begin
        got_if = if_valid;
        got_dm = dm_valid;
        done   = 1;
      end else if (n >= budget) begin
        n    = -1;
        done = 1;
      end else begin
        n++;
        tick();
      end
    end
  endtask

  task automatic do_reset();
    if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if_req = 0; dm_req = 0; dm_we = 0; flush = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    reset = 1;
    #1 reset = 0;
    #2;
    n_tests++;
    if ({mem_en, mem_we, if_valid, dm_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {mem_en, mem_we, if_valid, dm_valid});
    end
    n_tests++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0/0", mem_addr, mem_wdata);
    end
    n_tests++;
    if (if_rdata !== '0 || dm_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_rdata: got if %h dm %h expected 0/0", if_rdata, dm_rdata);
    end
    n_tests++;
    if ({stall_if, stall_mem} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_stalls: got %b expected 00", {stall_if, stall_mem});
    end
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic test_fetch();
    exp_t e;
    tick();
    if_req = 1; if_addr = 12'h010;
    e.is_dm = 0; e.data = mem_val(12'h010); exp_q.push_back(e);
    @(negedge clk);  // cycle 0: IDLE
    n_tests++;
    if (stall_if !== 1'b1 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c0: got stall_if %b mem_en %b expected 1 0", stall_if, mem_en);
    end
    tick(); @(negedge clk);  // cycle 1: first BUSY
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin
      n_fail++;
      $display("FAIL fetch_c1: got en %b we %b addr %h expected 1 0 010", mem_en, mem_we, mem_addr);
    end
    tick(); @(negedge clk);  // cycle 2: last BUSY
    n_tests++;
    if (mem_en !== 1'b0 || mem_addr !== 12'h010 || stall_if !== 1'b1 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c2: got en %b addr %h stall %b valid %b expected 0 010 1 0",
               mem_en, mem_addr, stall_if, if_valid);
    end
    tick(); @(negedge clk);  // cycle 3: DONE
    n_tests++;
    if (if_valid !== 1'b1 || stall_if !== 1'b0 || dm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_c3: got if_valid %b stall_if %b dm_valid %b expected 1 0 0",
               if_valid, stall_if, dm_valid);
    end
    e = exp_q.pop_front();
    n_tests++;
    if (if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL fetch_data: got %h expected %h", if_rdata, e.data);
    end
    tick(); if_req = 0;
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse: got if_valid %b expected 0", if_valid);
    end
  endtask

  task automatic test_load_store();
    exp_t e;
    int n; bit gi, gd;
    logic [DATA_W-1:0] prev_dm;
    // load
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 12'h030;
    e.is_dm = 1; e.data = mem_val(12'h030); exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gd !== 1'b1 || gi !== 1'b0) begin
      n_fail++;
      $display("FAIL load_timing: got n %0d if %b dm %b expected %0d 0 1", n, gi, gd, MEM_LAT + 1);
    end
    n_tests++;
    if (dm_rdata !== e.data[DATA_W-1:0]) begin
      n_fail++;
      $display("FAIL load_data: got %h expected %h", dm_rdata, e.data[DATA_W-1:0]);
    end
    prev_dm = e.data[DATA_W-1:0];
    tick(); dm_req = 0;
    // store
    tick();
    dm_req = 1; dm_we = 1; dm_addr = 12'h020; dm_wdata = 8'hC3;
    e.is_dm = 1; e.data = {11'b0, prev_dm}; exp_q.push_back(e);
    @(negedge clk);
    n_tests++;
    if (stall_mem !== 1'b1) begin
      n_fail++;
      $display("FAIL store_stall: got %b expected 1", stall_mem);
    end
    tick(); @(negedge clk);  // first BUSY
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h020 || mem_wdata !== 19'h000C3) begin
      n_fail++;
      $display("FAIL store_bus: got en %b we %b addr %h wdata %h expected 1 1 020 000c3",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    tick();
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT - 1 || gd !== 1'b1 || gi !== 1'b0) begin
      n_fail++;
      $display("FAIL store_timing: got n %0d if %b dm %b expected %0d 0 1", n, gi, gd, MEM_LAT - 1);
    end
    n_tests++;
    if (dm_rdata !== e.data[DATA_W-1:0]) begin
      n_fail++;
      $display("FAIL store_keeps_rdata: got %h expected %h", dm_rdata, e.data[DATA_W-1:0]);
    end
    tick(); dm_req = 0; dm_we = 0;
    // fetch back the stored word: zero-extended byte
    tick();
    if_req = 1; if_addr = 12'h020;
    e.is_dm = 0; e.data = 19'h000C3; exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gi !== 1'b1 || if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL store_readback: got n %0d valid %b data %h expected %0d 1 %h",
               n, gi, if_rdata, MEM_LAT + 1, e.data);
    end
    tick(); if_req = 0;
  endtask

  task automatic test_priority();
    exp_t e;
    int n; bit gi, gd;
    tick();
    if_req = 1; if_addr = 12'h040;
    dm_req = 1; dm_we = 0; dm_addr = 12'h050;
    e.is_dm = 1; e.data = mem_val(12'h050); exp_q.push_back(e);
    e.is_dm = 0; e.data = mem_val(12'h040); exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gd !== 1'b1 || gi !== 1'b0 || dm_rdata !== e.data[DATA_W-1:0]) begin
      n_fail++;
      $display("FAIL prio_first: got n %0d if %b dm %b data %h expected %0d 0 1 %h",
               n, gi, gd, dm_rdata, MEM_LAT + 1, e.data[DATA_W-1:0]);
    end
    tick(); dm_req = 0;
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gi !== 1'b1 || gd !== 1'b0 || if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL prio_second: got n %0d if %b dm %b data %h expected %0d 1 0 %h",
               n, gi, gd, if_rdata, MEM_LAT + 1, e.data);
    end
    tick(); if_req = 0;
  endtask

  task automatic test_flush();
    exp_t e;
    int n; bit gi, gd;
    // flush in first BUSY cycle kills the fetch
    tick();
    if_req = 1; if_addr = 12'h060;
    tick(); flush = 1;
    @(negedge clk);
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_access_runs: got mem_en %b expected 1", mem_en);
    end
    tick(); flush = 0;
    tick(); @(negedge clk);  // DONE
    n_tests++;
    if (if_valid !== 1'b0 || stall_if !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_kill: got if_valid %b stall_if %b expected 0 1", if_valid, stall_if);
    end
    // next fetch served normally from IDLE
    tick(); if_addr = 12'h070;
    e.is_dm = 0; e.data = mem_val(12'h070); exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gi !== 1'b1 || if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL flush_next: got n %0d valid %b data %h expected %0d 1 %h",
               n, gi, if_rdata, MEM_LAT + 1, e.data);
    end
    tick(); if_req = 0;
    // flush arriving in DONE itself
    tick(); if_req = 1; if_addr = 12'h071;
    tick(); tick(); tick(); flush = 1;
    @(negedge clk);
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_done: got if_valid %b expected 0", if_valid);
    end
    tick(); flush = 0; if_req = 0;
    // flush held during a data load and an IDLE grant has no effect
    tick(); flush = 1;
    dm_req = 1; dm_we = 0; dm_addr = 12'h072;
    e.is_dm = 1; e.data = mem_val(12'h072); exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gd !== 1'b1 || dm_rdata !== e.data[DATA_W-1:0]) begin
      n_fail++;
      $display("FAIL flush_dm_unaffected: got n %0d valid %b data %h expected %0d 1 %h",
               n, gd, dm_rdata, MEM_LAT + 1, e.data[DATA_W-1:0]);
    end
    tick(); dm_req = 0; if_req = 1; if_addr = 12'h073;  // IDLE with flush still high
    e.is_dm = 0; e.data = mem_val(12'h073); exp_q.push_back(e);
    tick(); flush = 0;
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT || gi !== 1'b1 || if_rdata !== e.data) begin
      n_fail++;
      $display("FAIL flush_idle_ignored: got n %0d valid %b data %h expected %0d 1 %h",
               n, gi, if_rdata, MEM_LAT, e.data);
    end
    tick(); if_req = 0;
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    int n; bit gi, gd, seen;
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 12'h080;
    tick();  // first BUSY
    #2 reset = 0;
    #1;
    n_tests++;
    if ({mem_en, mem_we, if_valid, dm_valid} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL midreset_bus: got en %b we %b ifv %b dmv %b addr %h wdata %h expected all 0",
               mem_en, mem_we, if_valid, dm_valid, mem_addr, mem_wdata);
    end
    n_tests++;
    if (if_rdata !== '0 || dm_rdata !== '0) begin
      n_fail++;
      $display("FAIL midreset_rdata: got if %h dm %h expected 0/0", if_rdata, dm_rdata);
    end
    dm_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dm_valid || if_valid) seen = 1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abandoned: got valid %b expected 0", seen);
    end
    tick();
    dm_req = 1; dm_addr = 12'h080;
    e.is_dm = 1; e.data = mem_val(12'h080); exp_q.push_back(e);
    wait_valid(20, n, gi, gd);
    e = exp_q.pop_front();
    n_tests++;
    if (n !== MEM_LAT + 1 || gd !== 1'b1 || dm_rdata !== e.data[DATA_W-1:0]) begin
      n_fail++;
      $display("FAIL midreset_rerequest: got n %0d valid %b data %h expected %0d 1 %h",
               n, gd, dm_rdata, MEM_LAT + 1, e.data[DATA_W-1:0]);
    end
    tick(); dm_req = 0;
  endtask

  // Both requesters held high for four back-to-back accesses from reset.
  task automatic test_back_to_back_contest();
    exp_t e;
    int n; bit gi, gd;
    do_reset();
    tick();
    if_req = 1; if_addr = 12'h090;
    dm_req = 1; dm_we = 0; dm_addr = 12'h0A0;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      e.is_dm = (k % 2 == 0);
`else
      e.is_dm = 1;
`endif
      e.data = e.is_dm ? mem_val(12'h0A0) : mem_val(12'h090);
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(20, n, gi, gd);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL contest_%0d_queue: got empty queue expected entry", k);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (n !== MEM_LAT + 1 || gd !== e.is_dm || gi !== !e.is_dm) begin
          n_fail++;
          $display("FAIL contest_%0d_grant: got n %0d if %b dm %b expected %0d %b %b",
                   k, n, gi, gd, MEM_LAT + 1, !e.is_dm, e.is_dm);
        end
        n_tests++;
        if (e.is_dm ? (dm_rdata !== e.data[DATA_W-1:0]) : (if_rdata !== e.data)) begin
          n_fail++;
          $display("FAIL contest_%0d_data: got if %h dm %h expected %h", k, if_rdata, dm_rdata, e.data);
        end
      end
      tick();
    end
    if_req = 0; dm_req = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_store();
    test_priority();
    test_flush();
    test_reset_mid_access();
    test_back_to_back_contest();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
